// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame deframer.
//   state_e       : deframer FSM states
//   SYNC_BYTE_DEF : default frame delimiter
//   BIT_CNT_W     : bit-within-byte counter width
//   FILL_W        : width of the saturating fill counter used while hunting
//   idx_w()       : width needed to index FRAME_BYTES payload bytes
package serial_frame_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_e;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned BIT_CNT_W     = 3;
  localparam int unsigned FILL_W        = 4;
  localparam logic [3:0]  FILL_FULL     = 4'd8;

  // Byte index runs 0..n-1; at least one bit even for single-byte frames.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_frame_deframer_byte_assembler.sv
// Bit-level front end: MSB-first shift register, fill and bit counters.
//   clk, rst_n        : clock, async active-low reset
//   i_bit_tick        : bit sample strobe
//   i_bit_in          : serial data
//   i_restart         : realign the byte boundary (bit counter to 0)
//   o_sr_next_c       : shift register value including the current bit
//   o_full_c          : at least 8 bits shifted since reset, including this one
//   o_byte_done_c     : current tick completes a byte on the aligned boundary
module serial_frame_deframer_byte_assembler
  import serial_frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_bit_tick,
  input  logic       i_bit_in,
  input  logic       i_restart,
  output logic [7:0] o_sr_next_c,
  output logic       o_full_c,
  output logic       o_byte_done_c
);

  logic [7:0]           r_sr;
  logic [FILL_W-1:0]    r_fill;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [7:0]           w_sr_next;

  assign w_sr_next = {r_sr[6:0], i_bit_in};

  // Fill count only matters until it saturates; once full the hunt slides freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr      <= '0;
      r_fill    <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (i_bit_tick) begin
        r_sr <= w_sr_next;
        if (r_fill != FILL_FULL) r_fill <= r_fill + FILL_W'(1);
      end
      if (i_restart)       r_bit_cnt <= '0;
      else if (i_bit_tick) r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
    end
  end

  assign o_sr_next_c   = w_sr_next;
  assign o_full_c      = (r_fill >= (FILL_FULL - FILL_W'(1)));
  assign o_byte_done_c = i_bit_tick && (r_bit_cnt == BIT_CNT_W'(7));

endmodule

// File: rtl/serial_frame_deframer.sv
// Sync-hunting frame deframer with a valid/ready payload holding register.
//   clk, rst_n    : clock, async active-low reset
//   bit_tick      : one-clk bit sample strobe
//   bit_in        : serial data, MSB first
//   byte_data     : payload byte            byte_valid : byte_data unconsumed
//   byte_ready    : consumer accepts        frame_start: byte is payload index 0
//   locked        : FSM not hunting         overflow   : sticky dropped-byte flag
//   sync_err_cnt  : saturating count of failed delimiter re-checks
module serial_frame_deframer
  import serial_frame_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned FRAME_BYTES = 4,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_tick,
  input  logic             bit_in,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             frame_start,
  output logic             locked,
  output logic             overflow,
  output logic [ERR_W-1:0] sync_err_cnt
);

  localparam int unsigned IDX_W = idx_w(FRAME_BYTES);

  state_e           r_state, w_state_next;
  logic [IDX_W-1:0] r_byte_idx, w_idx_next;
  logic [7:0]       r_byte_data;
  logic             r_byte_valid, r_frame_start, r_locked, r_overflow;
  logic [ERR_W-1:0] r_err_cnt;

  logic [7:0] w_sr_next;
  logic       w_full, w_byte_done, w_restart, w_load, w_err_inc, w_first;

  serial_frame_deframer_byte_assembler u_asm (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_bit_tick    (bit_tick),
    .i_bit_in      (bit_in),
    .i_restart     (w_restart),
    .o_sr_next_c   (w_sr_next),
    .o_full_c      (w_full),
    .o_byte_done_c (w_byte_done)
  );

  // State and byte index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HUNT;
      r_byte_idx <= '0;
    end else begin
      r_state    <= w_state_next;
      r_byte_idx <= w_idx_next;
    end
  end

  // Next-state: hunt for delimiter, cut payload bytes, re-check delimiter.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_byte_idx;
    w_restart    = 1'b0;
    w_load       = 1'b0;
    w_err_inc    = 1'b0;
    case (r_state)
      HUNT: begin
        if (bit_tick && w_full && (w_sr_next == SYNC_BYTE)) begin
          w_state_next = PAYLOAD;
          w_idx_next   = '0;
          w_restart    = 1'b1;
        end
      end
      PAYLOAD: begin
        if (w_byte_done) begin
          w_load = 1'b1;
          if (r_byte_idx == IDX_W'(FRAME_BYTES - 1)) begin
            w_state_next = CHECK;
            w_idx_next   = '0;
          end else begin
            w_idx_next = r_byte_idx + IDX_W'(1);
          end
        end
      end
      CHECK: begin
        if (w_byte_done) begin
          if (w_sr_next == SYNC_BYTE) begin
            w_state_next = PAYLOAD;
            w_idx_next   = '0;
          end else begin
            w_state_next = HUNT;
            w_err_inc    = 1'b1;
          end
        end
      end
      default: w_state_next = HUNT;
    endcase
  end

  assign w_first = (r_byte_idx == '0);

  // Holding register: a new byte loads only if the slot is empty or being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_data   <= '0;
      r_byte_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_overflow    <= 1'b0;
      r_locked      <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      if (w_load) begin
        if (!r_byte_valid || byte_ready) begin
          r_byte_data   <= w_sr_next;
          r_byte_valid  <= 1'b1;
          r_frame_start <= w_first;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (r_byte_valid && byte_ready) begin
        r_byte_valid  <= 1'b0;
        r_frame_start <= 1'b0;
      end
      r_locked <= (w_state_next != HUNT);
      if (w_err_inc && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign byte_data    = r_byte_data;
  assign byte_valid   = r_byte_valid;
  assign frame_start  = r_frame_start;
  assign locked       = r_locked;
  assign overflow     = r_overflow;
  assign sync_err_cnt = r_err_cnt;

endmodule
